// File: rtl/exec_pkg.sv
// ---------------------------------------------------------------------------
// exec_pkg
//   Shared definitions for the execute/writeback controller: data and address
//   widths, instruction field positions, opcode and FSM state encodings, and
//   small opcode-classification helpers used by the controller.
// ---------------------------------------------------------------------------
package exec_pkg;

    // Widths
    localparam int DATA_W  = 8;   // register-file data width
    localparam int ADDR_W  = 3;   // register-file address width (8 registers)
    localparam int INSTR_W = 16;  // instruction width

    // Instruction field positions
    localparam int OP_MSB   = 15;
    localparam int OP_LSB   = 12;
    localparam int RD_MSB   = 11;
    localparam int RD_LSB   = 9;
    localparam int RS1_MSB  = 8;
    localparam int RS1_LSB  = 6;
    localparam int RS2_MSB  = 5;
    localparam int RS2_LSB  = 3;
    localparam int IMM8_MSB = 7;
    localparam int IMM6_MSB = 5;

    // Opcodes; 11..15 are undefined
    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_AND  = 4'd3,
        OP_OR   = 4'd4,
        OP_XOR  = 4'd5,
        OP_SLT  = 4'd6,
        OP_ADDI = 4'd7,
        OP_LI   = 4'd8,
        OP_SHL  = 4'd9,
        OP_SHR  = 4'd10
    } opcode_e;

    // Controller states, one instruction in flight
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_DECODE    = 2'd1,
        ST_EXECUTE   = 2'd2,
        ST_WRITEBACK = 2'd3
    } state_e;

    // True for the ALU ops that produce a result for rd (and update Z/C)
    function automatic logic writes_rd(input logic [3:0] op);
        logic w;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
            OP_SLT, OP_ADDI, OP_LI, OP_SHL, OP_SHR: w = 1'b1;
            default:                                w = 1'b0;
        endcase
        return w;
    endfunction

    // True for opcodes outside the defined set
    function automatic logic is_illegal(input logic [3:0] op);
        logic ill;
        if (op == OP_NOP) begin
            ill = 1'b0;
        end else begin
            ill = !writes_rd(op);
        end
        return ill;
    endfunction

endpackage

// File: rtl/exec_alu.sv
// ---------------------------------------------------------------------------
// exec_alu
//   Purely combinational ALU for the execute stage.
//   Ports:
//     op     in  4    opcode (exec_pkg::opcode_e encoding)
//     a, b   in  N    operands captured from the register file
//     imm    in  8    instr[7:0]; imm8 for LI, low 6 bits are imm6 for ADDI
//     result out N    modulo-2^N result (0 for NOP / undefined opcodes)
//     z      out 1    result == 0
//     c      out 1    carry-out for ADD/ADDI, borrow for SUB, else 0
// ---------------------------------------------------------------------------
module exec_alu
    import exec_pkg::*;
#(
    parameter int N = DATA_W
) (
    input  logic [3:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [7:0]   imm,
    output logic [N-1:0] result,
    output logic         z,
    output logic         c
);

    logic [N-1:0] imm6_sext_s;
    logic [N:0]   wide_s;
    logic [2:0]   shamt_s;

    assign imm6_sext_s = {{(N-6){imm[IMM6_MSB]}}, imm[IMM6_MSB:0]};
    assign shamt_s     = b[2:0];

    // Result and carry selection per opcode
    always_comb begin
        result = {N{1'b0}};
        c      = 1'b0;
        wide_s = {(N+1){1'b0}};
        case (op)
            OP_ADD: begin
                wide_s = {1'b0, a} + {1'b0, b};
                result = wide_s[N-1:0];
                c      = wide_s[N];
            end
            OP_SUB: begin
                // The extra top bit of the wrapped difference is set exactly when a < b
                wide_s = {1'b0, a} - {1'b0, b};
                result = wide_s[N-1:0];
                c      = wide_s[N];
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SLT:  result = {{(N-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_ADDI: begin
                wide_s = {1'b0, a} + {1'b0, imm6_sext_s};
                result = wide_s[N-1:0];
                c      = wide_s[N];
            end
            OP_LI:   result = N'(imm);
            OP_SHL:  result = a << shamt_s;
            OP_SHR:  result = a >> shamt_s;
            default: begin
                result = {N{1'b0}};
                c      = 1'b0;
            end
        endcase
    end

    assign z = (result == {N{1'b0}});

endmodule

// File: rtl/exec_ctrl_unit.sv
// ---------------------------------------------------------------------------
// exec_ctrl_unit
//   Multicycle execute/writeback controller sitting in front of an 8x8
//   register file. One instruction is accepted per valid/ready handshake and
//   walks IDLE -> DECODE -> EXECUTE -> WRITEBACK, so at most one instruction
//   is in flight and throughput is one instruction every four cycles.
//   Ports:
//     clk          in   1     clock, all state on posedge
//     rst          in   1     synchronous active-high reset
//     instr        in   IW    instruction word
//     instr_valid  in   1     instr present
//     instr_ready  out  1     high in IDLE while rst is low
//     ra1, ra2     out  RA_W  register-file read selects (rs1, rs2)
//     rd1, rd2     in   N     register-file read data (combinational)
//     wa3          out  RA_W  write address (rd)
//     wd3          out  N     write data
//     we3          out  1     write-enable pulse in WRITEBACK
//     done         out  1     completion pulse in WRITEBACK
//     illegal      out  1     undefined-opcode pulse in WRITEBACK
//     flag_z       out  1     zero flag of the last ALU op
//     flag_c       out  1     carry/borrow flag of the last ALU op
// ---------------------------------------------------------------------------
module exec_ctrl_unit
    import exec_pkg::*;
#(
    parameter int N    = DATA_W,
    parameter int RA_W = ADDR_W,
    parameter int IW   = INSTR_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [IW-1:0]   instr,
    input  logic            instr_valid,
    output logic            instr_ready,
    output logic [RA_W-1:0] ra1,
    output logic [RA_W-1:0] ra2,
    input  logic [N-1:0]    rd1,
    input  logic [N-1:0]    rd2,
    output logic [RA_W-1:0] wa3,
    output logic [N-1:0]    wd3,
    output logic            we3,
    output logic            done,
    output logic            illegal,
    output logic            flag_z,
    output logic            flag_c
);

    state_e          state_r;
    state_e          state_next_s;
    logic [IW-1:0]   instr_r;
    logic [N-1:0]    op_a_r;
    logic [N-1:0]    op_b_r;
    logic            we3_r;
    logic [3:0]      op_s;
    logic [RA_W-1:0] rd_s;
    logic [N-1:0]    alu_result_s;
    logic            alu_z_s;
    logic            alu_c_s;

    assign op_s = instr_r[OP_MSB:OP_LSB];
    assign rd_s = instr_r[RD_MSB:RD_LSB];

    // Read selects come straight from the latched instruction register, so
    // they are stable for the whole DECODE cycle in which rd1/rd2 are captured.
    assign ra1 = instr_r[RS1_MSB:RS1_LSB];
    assign ra2 = instr_r[RS2_MSB:RS2_LSB];

    // Ready only in IDLE; a reset in the same cycle blocks the handshake.
    assign instr_ready = (state_r == ST_IDLE) && !rst;

    // The write enable is masked by rst so that a reset arriving during
    // WRITEBACK suppresses the register-file write at that very edge.
    assign we3 = we3_r && !rst;

    exec_alu #(
        .N (N)
    ) u_alu (
        .op     (op_s),
        .a      (op_a_r),
        .b      (op_b_r),
        .imm    (instr_r[IMM8_MSB:0]),
        .result (alu_result_s),
        .z      (alu_z_s),
        .c      (alu_c_s)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (instr_valid) begin
                    state_next_s = ST_DECODE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_DECODE:    state_next_s = ST_EXECUTE;
            ST_EXECUTE:   state_next_s = ST_WRITEBACK;
            ST_WRITEBACK: state_next_s = ST_IDLE;
            default:      state_next_s = ST_IDLE;
        endcase
    end

    // Instruction/operand capture, ALU result registration and output pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_r <= {IW{1'b0}};
            op_a_r  <= {N{1'b0}};
            op_b_r  <= {N{1'b0}};
            wa3     <= {RA_W{1'b0}};
            wd3     <= {N{1'b0}};
            we3_r   <= 1'b0;
            done    <= 1'b0;
            illegal <= 1'b0;
            flag_z  <= 1'b0;
            flag_c  <= 1'b0;
        end else begin
            // Pulses last exactly one cycle unless re-armed below
            we3_r   <= 1'b0;
            done    <= 1'b0;
            illegal <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (instr_valid) begin
                        instr_r <= instr;
                    end
                end
                ST_DECODE: begin
                    op_a_r <= rd1;
                    op_b_r <= rd2;
                end
                ST_EXECUTE: begin
                    wd3     <= alu_result_s;
                    wa3     <= rd_s;
                    // $0 is never written so it always reads as zero
                    we3_r   <= writes_rd(op_s) && (rd_s != {RA_W{1'b0}});
                    done    <= 1'b1;
                    illegal <= is_illegal(op_s);
                    // NOP and undefined opcodes leave both flags untouched;
                    // the ALU reports C=0 for the non-arithmetic ops, which
                    // clears the carry as intended.
                    if (writes_rd(op_s)) begin
                        flag_z <= alu_z_s;
                        flag_c <= alu_c_s;
                    end
                end
                ST_WRITEBACK: begin
                    // Pulses fall back to 0 via the defaults above
                end
                default: begin
                    we3_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exec_ctrl_unit.sv
// ---------------------------------------------------------------------------
// tb_exec_ctrl_unit
//   Directed-vector bench with a scoreboard. Each issued instruction pushes
//   its hand-computed WRITEBACK response; a monitor pops and compares it
//   whenever done is seen. A small register-file model closes the loop.
// ---------------------------------------------------------------------------
module tb_exec_ctrl_unit;

    typedef struct {
        logic       we3;
        logic [2:0] wa3;
        logic [7:0] wd3;
        logic       chk_wd;
        logic       illegal;
        logic       z;
        logic       c;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [2:0]  ra1, ra2, wa3;
    logic [7:0]  rd1, rd2, wd3;
    logic        we3, done, illegal, flag_z, flag_c;

    logic [7:0]  rf [8];
    logic        rf_clr;

    exp_t        sb_q [$];
    exp_t        mon_e;
    int          n_cmp = 0;
    int          n_bad = 0;

    exec_ctrl_unit dut (
        .clk         (clk),
        .rst         (rst),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .ra1         (ra1),
        .ra2         (ra2),
        .rd1         (rd1),
        .rd2         (rd2),
        .wa3         (wa3),
        .wd3         (wd3),
        .we3         (we3),
        .done        (done),
        .illegal     (illegal),
        .flag_z      (flag_z),
        .flag_c      (flag_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-file model: combinational reads, write on posedge when we3
    always @(posedge clk) begin
        if (rf_clr) begin
            for (int i = 0; i < 8; i++) rf[i] <= 8'h00;
        end else if (we3) begin
            rf[wa3] <= wd3;
        end
    end
    assign rd1 = rf[ra1];
    assign rd2 = rf[ra2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic [15:0] ins, input logic e_we, input logic [7:0] e_wd,
                            input logic e_chk_wd, input logic e_ill, input logic e_z, input logic e_c);
        exp_t e;
        e.we3     = e_we;
        e.wa3     = ins[11:9];
        e.wd3     = e_wd;
        e.chk_wd  = e_chk_wd;
        e.illegal = e_ill;
        e.z       = e_z;
        e.c       = e_c;
        sb_q.push_back(e);
    endtask

    // Issue one instruction from IDLE and wait for the controller to return to IDLE
    task automatic run_instr(input logic [15:0] ins, input logic e_we, input logic [7:0] e_wd,
                             input logic e_chk_wd, input logic e_ill, input logic e_z, input logic e_c);
        int busy;
        @(negedge clk);
        chk("ready_before_issue", instr_ready, 1);
        instr       = ins;
        instr_valid = 1'b1;
        push_exp(ins, e_we, e_wd, e_chk_wd, e_ill, e_z, e_c);
        @(negedge clk);
        instr_valid = 1'b0;
        chk("ra1_decode", ra1, ins[8:6]);
        chk("ra2_decode", ra2, ins[5:3]);
        busy = 0;
        while (instr_ready !== 1'b1 && busy < 10) begin
            busy++;
            @(negedge clk);
        end
        chk("busy_cycles", busy, 3);
    endtask

    // Monitor: compare every completion against the scoreboard
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done=1 expected no completion at %0t", $time);
            end else begin
                mon_e = sb_q.pop_front();
                chk("sb_we3", we3, mon_e.we3);
                chk("sb_wa3", wa3, mon_e.wa3);
                if (mon_e.chk_wd) chk("sb_wd3", wd3, mon_e.wd3);
                chk("sb_illegal", illegal, mon_e.illegal);
                chk("sb_flag_z", flag_z, mon_e.z);
                chk("sb_flag_c", flag_c, mon_e.c);
            end
        end else if (we3 === 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL stray_we3: got we3=1 expected 0 outside done at %0t", $time);
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish expected finish by 100000");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] prog [3];
        int          hs;
        int          hs_cyc [3];
        int          wcnt;

        rst         = 1'b1;
        rf_clr      = 1'b1;
        instr       = 16'h0000;
        instr_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        // Reset state
        chk("rst_ready", instr_ready, 0);
        chk("rst_we3", we3, 0);
        chk("rst_done", done, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_flags", {flag_z, flag_c}, 0);
        chk("rst_wa3_wd3", {wa3, wd3}, 0);
        chk("rst_ra", {ra1, ra2}, 0);
        rf_clr = 1'b0;
        rst    = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", instr_ready, 1);

        // T1: LI r1,0x05
        run_instr(16'h8205, 1'b1, 8'h05, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("rf_r1", rf[1], 8'h05);

        // T2: LI r2,0xFB ; ADD r3,r1,r2
        run_instr(16'h84FB, 1'b1, 8'hFB, 1'b1, 1'b0, 1'b0, 1'b0);
        run_instr(16'h1650, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("rf_r3_add", rf[3], 8'h00);

        // T3: ALU coverage with r1=0x05, r2=0xFB
        run_instr(16'h2850, 1'b1, 8'h0A, 1'b1, 1'b0, 1'b0, 1'b1); // SUB r4,r1,r2
        run_instr(16'h6A50, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0); // SLT r5,r1,r2
        run_instr(16'h9C48, 1'b1, 8'hA0, 1'b1, 1'b0, 1'b0, 1'b0); // SHL r6,r1,r1
        run_instr(16'h3850, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0); // AND r4,r1,r2
        run_instr(16'h4A50, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0); // OR  r5,r1,r2
        run_instr(16'h5E50, 1'b1, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b0); // XOR r7,r1,r2
        run_instr(16'hAC88, 1'b1, 8'h07, 1'b1, 1'b0, 1'b0, 1'b0); // SHR r6,r2,r1
        run_instr(16'h7EBF, 1'b1, 8'hFA, 1'b1, 1'b0, 1'b0, 1'b1); // ADDI r7,r2,-1
        run_instr(16'h7E41, 1'b1, 8'h06, 1'b1, 1'b0, 1'b0, 1'b0); // ADDI r7,r1,+1
        run_instr(16'h6A88, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0); // SLT r5,r2,r1
        chk("rf_r7", rf[7], 8'h06);
        chk("rf_r6", rf[6], 8'h07);

        // T4: write to r0 suppressed; illegal and NOP hold flags
        run_instr(16'h807F, 1'b0, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b0); // LI r0,0x7F
        chk("rf_r0", rf[0], 8'h00);
        run_instr(16'h1650, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1); // ADD r3,r1,r2
        run_instr(16'hF650, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1); // opcode 0xF
        run_instr(16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1); // NOP

        // T5: instr_valid held high for 12 cycles, 3 instructions
        prog[0] = 16'h8611; // LI r3,0x11
        prog[1] = 16'h1850; // ADD r4,r1,r2
        prog[2] = 16'h2A88; // SUB r5,r2,r1
        hs = 0;
        @(negedge clk);
        instr_valid = 1'b1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            if (instr_ready === 1'b1 && hs < 3) begin
                instr      = prog[hs];
                hs_cyc[hs] = cyc;
                case (hs)
                    0:       push_exp(prog[0], 1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0);
                    1:       push_exp(prog[1], 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
                    default: push_exp(prog[2], 1'b1, 8'hF6, 1'b1, 1'b0, 1'b0, 1'b0);
                endcase
                hs++;
            end else begin
                instr = 16'h83EE; // LI r1,0xEE: must never be accepted
            end
            @(negedge clk);
        end
        instr_valid = 1'b0;
        chk("t5_handshakes", hs, 3);
        chk("t5_gap01", hs_cyc[1] - hs_cyc[0], 4);
        chk("t5_gap12", hs_cyc[2] - hs_cyc[1], 4);
        @(negedge clk);
        chk("t5_rf_r3", rf[3], 8'h11);
        chk("t5_rf_r1", rf[1], 8'h05);

        // T6: reset during WRITEBACK of ADD r3,r1,r2
        @(negedge clk);
        instr       = 16'h1650;
        instr_valid = 1'b1;
        push_exp(16'h1650, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        instr_valid = 1'b0;
        wcnt = 0;
        while (done !== 1'b1 && wcnt < 10) begin
            wcnt++;
            @(negedge clk);
        end
        chk("t6_reached_wb", done, 1);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("t6_no_write_r3", rf[3], 8'h11);
        chk("t6_outs_zero", {we3, done, illegal, flag_z, flag_c}, 0);
        chk("t6_addr_data_zero", {wa3, wd3, ra1, ra2}, 0);
        chk("t6_ready_in_rst", instr_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_ready_after", instr_ready, 1);

        repeat (3) @(negedge clk);
        chk("sb_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
